i_cache_tag_array: RTL and testbench

//   Parametrised, set-associative tag store for the I-cache.

---
 rtl/i_cache_tag_array.sv | 170 +++++++++++++++++
 tb/tb_i_cache_tag_array.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/i_cache_tag_array.sv
// i_cache_tag_array: set-associative tag store for the I-cache.
// Holds a tag and a valid bit per (set, way). It gives a registered hit/miss,
// the hit way and a refill victim way, and it runs a sequential invalidate-all (flush).
// Handshake: a lookup or fill is accepted only in IDLE with flush_i low.
// An accepted lookup produces rsp_vld_o for exactly one cycle, one cycle later.
// Optional feature: define ICACHE_TAG_PARITY_EN to add per-entry even parity
// and the parity_err_o output.
module i_cache_tag_array #(
  parameter int SET_W = 6,
  parameter int TAG_W = 55,
  parameter int WAYS  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lookup_vld_i,
  input  logic [SET_W-1:0]    lookup_set_i,
  input  logic [TAG_W-1:0]    lookup_tag_i,
  output logic                rsp_vld_o,
  output logic                hit_o,
  output logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] hit_way_o,
  output logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] victim_way_o,
  input  logic                fill_vld_i,
  input  logic [SET_W-1:0]    fill_set_i,
  input  logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] fill_way_i,
  input  logic [TAG_W-1:0]    fill_tag_i,
  input  logic                flush_i,
`ifdef ICACHE_TAG_PARITY_EN
  output logic                parity_err_o,
`endif
  output logic                busy_o
);

  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int SETS  = 2 ** SET_W;

  typedef enum logic {S_IDLE = 1'b0, S_FLUSH = 1'b1} state_t;

  state_t              r_state;
  logic [SET_W-1:0]    r_cnt;
  logic [WAYS-1:0]     r_valid [SETS];
  logic [WAY_W-1:0]    r_rr    [SETS];
  logic [TAG_W-1:0]    r_tag   [SETS][WAYS];
`ifdef ICACHE_TAG_PARITY_EN
  logic                r_par   [SETS][WAYS];
  logic [WAYS-1:0]     w_bad;
  logic                w_par_err;
`endif

  logic                w_lookup_acc;
  logic                w_fill_acc;
  logic [WAYS-1:0]     w_match;
  logic                w_hit;
  logic [WAY_W-1:0]    w_hit_way;
  logic [WAY_W-1:0]    w_victim;
  logic [WAY_W-1:0]    w_next_rr;

  // Requests are taken only while idle and not colliding with a flush start.
  assign w_lookup_acc = lookup_vld_i && (r_state == S_IDLE) && !flush_i;
  assign w_fill_acc   = fill_vld_i   && (r_state == S_IDLE) && !flush_i;
  assign w_next_rr    = (fill_way_i == WAY_W'(WAYS - 1)) ? '0 : fill_way_i + 1'b1;
  assign busy_o       = (r_state == S_FLUSH);

  // Per-way compare against the looked-up set; a way with bad parity never matches.
  always_comb begin
    w_match = '0;
`ifdef ICACHE_TAG_PARITY_EN
    w_bad = '0;
`endif
    for (int w = 0; w < WAYS; w++) begin
`ifdef ICACHE_TAG_PARITY_EN
      w_bad[w]   = r_valid[lookup_set_i][w] &&
                   ((^r_tag[lookup_set_i][w]) != r_par[lookup_set_i][w]);
      w_match[w] = r_valid[lookup_set_i][w] && !w_bad[w] &&
                   (r_tag[lookup_set_i][w] == lookup_tag_i);
`else
      w_match[w] = r_valid[lookup_set_i][w] &&
                   (r_tag[lookup_set_i][w] == lookup_tag_i);
`endif
    end
  end

`ifdef ICACHE_TAG_PARITY_EN
  assign w_par_err = |w_bad;
`endif

  // Hit way and victim selection; descending loops make the lowest index win.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_victim  = r_rr[lookup_set_i];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_match[w]) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!r_valid[lookup_set_i][w]) begin
        w_victim = WAY_W'(w);
      end
    end
`ifdef ICACHE_TAG_PARITY_EN
    // A corrupted way is replaced before any plain invalid way.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_bad[w]) begin
        w_victim = WAY_W'(w);
      end
    end
`endif
  end

  // Control FSM, valid bits, round-robin pointers and registered lookup results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      rsp_vld_o    <= 1'b0;
      hit_o        <= 1'b0;
      hit_way_o    <= '0;
      victim_way_o <= '0;
`ifdef ICACHE_TAG_PARITY_EN
      parity_err_o <= 1'b0;
`endif
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else begin
      rsp_vld_o <= w_lookup_acc;
      if (w_lookup_acc) begin
        hit_o        <= w_hit;
        hit_way_o    <= w_hit_way;
        victim_way_o <= w_victim;
`ifdef ICACHE_TAG_PARITY_EN
        parity_err_o <= w_par_err;
      end else begin
        parity_err_o <= 1'b0;
`endif
      end
      case (r_state)
        S_IDLE: begin
          if (flush_i) begin
            r_state <= S_FLUSH;
            r_cnt   <= '0;
          end else if (w_fill_acc) begin
            r_valid[fill_set_i][fill_way_i] <= 1'b1;
            r_rr[fill_set_i]                <= w_next_rr;
          end
        end
        S_FLUSH: begin
          r_valid[r_cnt] <= '0;
          r_cnt          <= r_cnt + 1'b1;
          if (r_cnt == {SET_W{1'b1}}) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag (and parity) storage; not reset, qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (w_fill_acc) begin
      r_tag[fill_set_i][fill_way_i] <= fill_tag_i;
`ifdef ICACHE_TAG_PARITY_EN
      r_par[fill_set_i][fill_way_i] <= ^fill_tag_i;
`endif
    end
  end

endmodule

// File: tb/tb_i_cache_tag_array.sv
// Directed bench for i_cache_tag_array (SET_W=6, TAG_W=55, WAYS=2).
module tb_i_cache_tag_array;

  localparam int SET_W = 6;
  localparam int TAG_W = 55;
  localparam int WAY_W = 1;

  logic             clk;
  logic             rst;
  logic             lookup_vld_i;
  logic [SET_W-1:0] lookup_set_i;
  logic [TAG_W-1:0] lookup_tag_i;
  logic             rsp_vld_o;
  logic             hit_o;
  logic [WAY_W-1:0] hit_way_o;
  logic [WAY_W-1:0] victim_way_o;
  logic             fill_vld_i;
  logic [SET_W-1:0] fill_set_i;
  logic [WAY_W-1:0] fill_way_i;
  logic [TAG_W-1:0] fill_tag_i;
  logic             flush_i;
  logic             busy_o;
`ifdef ICACHE_TAG_PARITY_EN
  logic             parity_err_o;
`endif

  int checks;
  int failures;

  i_cache_tag_array dut (
    .clk          (clk),
    .rst          (rst),
    .lookup_vld_i (lookup_vld_i),
    .lookup_set_i (lookup_set_i),
    .lookup_tag_i (lookup_tag_i),
    .rsp_vld_o    (rsp_vld_o),
    .hit_o        (hit_o),
    .hit_way_o    (hit_way_o),
    .victim_way_o (victim_way_o),
    .fill_vld_i   (fill_vld_i),
    .fill_set_i   (fill_set_i),
    .fill_way_i   (fill_way_i),
    .fill_tag_i   (fill_tag_i),
    .flush_i      (flush_i),
`ifdef ICACHE_TAG_PARITY_EN
    .parity_err_o (parity_err_o),
`endif
    .busy_o       (busy_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    lookup_vld_i = 1'b0;
    fill_vld_i   = 1'b0;
    flush_i      = 1'b0;
  endtask

  task automatic do_fill(input logic [SET_W-1:0] s, input logic [WAY_W-1:0] w,
                         input logic [TAG_W-1:0] t);
    fill_vld_i = 1'b1; fill_set_i = s; fill_way_i = w; fill_tag_i = t;
    tick();
    fill_vld_i = 1'b0;
  endtask

  // Issue one lookup and check the response one cycle later.
  task automatic do_lookup(input string name, input logic [SET_W-1:0] s,
                           input logic [TAG_W-1:0] t, input logic exp_hit,
                           input logic [WAY_W-1:0] exp_way, input logic [WAY_W-1:0] exp_vic);
    lookup_vld_i = 1'b1; lookup_set_i = s; lookup_tag_i = t;
    tick();
    lookup_vld_i = 1'b0;
    check({name, "_rsp"}, 64'(rsp_vld_o), 64'd1);
    check({name, "_hit"}, 64'(hit_o), 64'(exp_hit));
    check({name, "_way"}, 64'(hit_way_o), 64'(exp_way));
    check({name, "_vic"}, 64'(victim_way_o), 64'(exp_vic));
  endtask

  initial begin
    int busy_cnt;
    int guard;
    logic rsp_seen;
    logic [TAG_W-1:0] ones;
    checks = 0; failures = 0;
    ones = '1;
    idle_inputs();
    lookup_set_i = '0; lookup_tag_i = '0;
    fill_set_i = '0; fill_way_i = '0; fill_tag_i = '0;

    // Reset
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp",  64'(rsp_vld_o), 64'd0);
    check("rst_hit",  64'(hit_o), 64'd0);
    check("rst_way",  64'(hit_way_o), 64'd0);
    check("rst_vic",  64'(victim_way_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    rst = 1'b1;
    tick();

    // 1. Cold miss
    do_lookup("t1", 6'd5, 55'h1234, 1'b0, 1'b0, 1'b0);
    tick();
    check("t1_rsp_drop", 64'(rsp_vld_o), 64'd0);

    // 2. Fill way 1, hit; outputs hold after the response
    do_fill(6'd5, 1'b1, 55'h1234);
    do_lookup("t2", 6'd5, 55'h1234, 1'b1, 1'b1, 1'b0);
    tick();
    check("t2_hold_rsp", 64'(rsp_vld_o), 64'd0);
    check("t2_hold_hit", 64'(hit_o), 64'd1);
    check("t2_hold_way", 64'(hit_way_o), 64'd1);
    do_lookup("t2_miss", 6'd5, 55'h9999, 1'b0, 1'b0, 1'b0);

    // 3. Full set: victim from round-robin pointer
    do_fill(6'd3, 1'b0, 55'hA);
    do_fill(6'd3, 1'b1, 55'hB);
    do_lookup("t3_c", 6'd3, 55'hC, 1'b0, 1'b0, 1'b0);
    do_fill(6'd3, 1'b0, 55'hA);
    do_lookup("t3_rr", 6'd3, 55'hC, 1'b0, 1'b0, 1'b1);
    do_lookup("t3_b", 6'd3, 55'hB, 1'b1, 1'b1, 1'b1);
    do_lookup("t3_a", 6'd3, 55'hA, 1'b1, 1'b0, 1'b1);
    // Last set, all-ones tag
    do_fill(6'd63, 1'b0, ones);
    do_lookup("t3_max", 6'd63, ones, 1'b1, 1'b0, 1'b1);

    // 4. Same-cycle lookup and fill of set 7: read-before-write
    lookup_vld_i = 1'b1; lookup_set_i = 6'd7; lookup_tag_i = 55'h55;
    fill_vld_i = 1'b1; fill_set_i = 6'd7; fill_way_i = 1'b0; fill_tag_i = 55'h55;
    tick();
    idle_inputs();
    check("t4_rsp", 64'(rsp_vld_o), 64'd1);
    check("t4_hit", 64'(hit_o), 64'd0);
    do_lookup("t4_next", 6'd7, 55'h55, 1'b1, 1'b0, 1'b1);

    // Back-to-back lookups
    lookup_vld_i = 1'b1; lookup_set_i = 6'd5; lookup_tag_i = 55'h1234;
    tick();
    check("b2b0_rsp", 64'(rsp_vld_o), 64'd1);
    check("b2b0_way", 64'(hit_way_o), 64'd1);
    lookup_set_i = 6'd7; lookup_tag_i = 55'h55;
    tick();
    lookup_vld_i = 1'b0;
    check("b2b1_rsp", 64'(rsp_vld_o), 64'd1);
    check("b2b1_hit", 64'(hit_o), 64'd1);
    check("b2b1_way", 64'(hit_way_o), 64'd0);

    // 5. Flush with a colliding lookup; lookups and a fill held during it
    flush_i = 1'b1; lookup_vld_i = 1'b1; lookup_set_i = 6'd5; lookup_tag_i = 55'h1234;
    tick();
    flush_i = 1'b0;
    fill_vld_i = 1'b1; fill_set_i = 6'd9; fill_way_i = 1'b0; fill_tag_i = 55'h77;
    rsp_seen = rsp_vld_o;
    busy_cnt = busy_o ? 1 : 0;
    guard = 0;
    while (busy_o && guard < 200) begin
      if (busy_cnt == 10) begin
        fill_vld_i = 1'b0;
        flush_i    = 1'b1;
      end else begin
        flush_i    = 1'b0;
      end
      tick();
      guard++;
      if (busy_o) busy_cnt++;
      rsp_seen = rsp_seen | rsp_vld_o;
    end
    idle_inputs();
    check("t5_busy_cycles", 64'(busy_cnt), 64'd64);
    check("t5_no_rsp", 64'(rsp_seen), 64'd0);
    do_lookup("t5_s5", 6'd5, 55'h1234, 1'b0, 1'b0, 1'b0);
    do_lookup("t5_s3", 6'd3, 55'hB, 1'b0, 1'b0, 1'b0);
    do_lookup("t5_s63", 6'd63, ones, 1'b0, 1'b0, 1'b0);
    do_lookup("t5_fill_drop", 6'd9, 55'h77, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a flush
    do_fill(6'd7, 1'b1, 55'h55);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    #2;
    check("midrst_busy", 64'(busy_o), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    check("midrst_busy_after", 64'(busy_o), 64'd0);
    do_lookup("midrst_s7", 6'd7, 55'h55, 1'b0, 1'b0, 1'b0);

`ifdef ICACHE_TAG_PARITY_EN
    // 6. Corrupted tag bit in set 5 way 1
    do_fill(6'd5, 1'b1, 55'h1234);
    do_lookup("t6_ok", 6'd5, 55'h1234, 1'b1, 1'b1, 1'b0);
    check("t6_ok_perr", 64'(parity_err_o), 64'd0);
    dut.r_tag[5][1] = 55'h1235;
    do_lookup("t6_bad", 6'd5, 55'h1235, 1'b0, 1'b0, 1'b1);
    check("t6_perr", 64'(parity_err_o), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
